// File: rtl/cap_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cap_dbg_pkg
// Purpose  : Shared constants and FSM encodings for the debug capture sink.
// Revision : 1.0
// ============================================================================
package cap_dbg_pkg;

    localparam int CAP_ST_W   = 3;
    localparam int CAP_DATA_W = 32;
    localparam int CAP_ADDR_W = 8;

    localparam logic [CAP_ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [CAP_ST_W-1:0] ST_ARMED = 3'd1;
    localparam logic [CAP_ST_W-1:0] ST_POST  = 3'd2;
    localparam logic [CAP_ST_W-1:0] ST_DONE  = 3'd3;

endpackage
`default_nettype wire

// File: rtl/cap_sink_ram.sv
`default_nettype none
// ============================================================================
// Module   : cap_sink_ram
// Purpose  : 1W1R synchronous sample buffer with registered read data.
// Revision : 1.0
// ============================================================================
module cap_sink_ram
    import cap_dbg_pkg::*;
#(
    parameter int DATA_W = CAP_DATA_W,
    parameter int ADDR_W = CAP_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Output register only updates on a read so the last readout is held.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cap_dbg_sink.sv
`default_nettype none
// ============================================================================
// Module   : cap_dbg_sink
// Purpose  : Capture sink with pre-trigger history, post-trigger length and
//            frozen random-access readout.
// Revision : 1.0
// ============================================================================
module cap_dbg_sink
    import cap_dbg_pkg::*;
#(
    parameter int DATA_W = CAP_DATA_W,
    parameter int ADDR_W = CAP_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   cap_data,
    input  logic                cap_data_vld,
    input  logic                cap_mode_vld,
    input  logic                arm,
    input  logic                trig_in,
    input  logic [DATA_W-1:0]   trig_mask,
    input  logic [DATA_W-1:0]   trig_val,
    input  logic [ADDR_W:0]     post_len,
    output logic [CAP_ST_W-1:0] cap_state,
    output logic                cap_done,
    output logic [ADDR_W:0]     cap_cnt,
    output logic [ADDR_W:0]     trig_pos,
    output logic                mode_lost,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_data_vld
);

    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_one   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr1  = ADDR_W'(1);

    logic [CAP_ST_W-1:0] r_state;
    logic [CAP_ST_W-1:0] w_next_state;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_start_ptr;
    logic [ADDR_W:0]     r_cap_cnt;
    logic [ADDR_W:0]     r_post_cnt;
    logic [ADDR_W:0]     r_trig_pos;
    logic                r_mode_lost;
    logic                r_mode_q;
    logic                r_rd_vld;
    logic                r_rd_zero;

    logic                w_capturing;
    logic                w_acc;
    logic                w_we;
    logic                w_mode_fall;
    logic                w_data_hit;
    logic                w_trig;
    logic                w_enter_done;
    logic                w_rd_go;
    logic [ADDR_W:0]     w_eff_len;
    logic [ADDR_W:0]     w_post_inc;
    logic [ADDR_W-1:0]   w_wr_ptr_nxt;
    logic [ADDR_W:0]     w_cnt_nxt;
    logic [ADDR_W:0]     w_post_nxt;
    logic [ADDR_W:0]     w_trig_pos_nxt;
    logic [ADDR_W-1:0]   w_start_nxt;
    logic [ADDR_W-1:0]   w_rd_phys;
    logic [DATA_W-1:0]   w_ram_q;

    assign w_eff_len   = (post_len > c_depth) ? c_depth : post_len;
    assign w_post_inc  = r_post_cnt + c_one;
    assign w_mode_fall = r_mode_q & ~cap_mode_vld;
    assign w_data_hit  = (trig_mask != '0) & cap_data_vld & cap_mode_vld &
                         ((cap_data & trig_mask) == trig_val);
    assign w_trig      = trig_in | w_data_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // arm low dominates; mode loss dominates a same-cycle trigger.
    always_comb begin
        w_next_state = r_state;
        if (!arm) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next_state = ST_ARMED;
                ST_ARMED: begin
                    if (w_mode_fall) begin
                        w_next_state = ST_DONE;
                    end else if (w_trig) begin
                        if ((w_eff_len == '0) || (w_acc && (w_eff_len == c_one))) begin
                            w_next_state = ST_DONE;
                        end else begin
                            w_next_state = ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (w_mode_fall || (w_acc && (w_post_inc >= w_eff_len))) begin
                        w_next_state = ST_DONE;
                    end
                end
                ST_DONE:  w_next_state = ST_DONE;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_capturing = (r_state == ST_ARMED) || (r_state == ST_POST);
        w_acc       = cap_data_vld & cap_mode_vld & w_capturing & arm;
        w_we        = w_acc & ~((r_state == ST_ARMED) & w_trig & (w_eff_len == '0));
        w_rd_go     = rd_en & (r_state == ST_DONE);
        cap_state   = r_state;
        cap_done    = (r_state == ST_DONE);
    end

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_cnt_nxt    = r_cap_cnt;
        w_post_nxt   = r_post_cnt;
        if (!arm) begin
            w_wr_ptr_nxt = '0;
            w_cnt_nxt    = '0;
            w_post_nxt   = '0;
        end else begin
            if (w_we) begin
                w_wr_ptr_nxt = r_wr_ptr + c_ptr1;
                if (r_cap_cnt != c_depth) begin
                    w_cnt_nxt = r_cap_cnt + c_one;
                end
            end
            if (r_state == ST_ARMED) begin
                w_post_nxt = (w_trig && w_we) ? c_one : '0;
            end else if ((r_state == ST_POST) && w_we) begin
                w_post_nxt = w_post_inc;
            end
        end
    end

    // Readout window and trigger position are frozen from the values the
    // buffer will hold once the DONE-entry edge has completed.
    assign w_enter_done   = (r_state != ST_DONE) && (w_next_state == ST_DONE);
    assign w_trig_pos_nxt = (w_cnt_nxt > w_post_nxt) ? (w_cnt_nxt - w_post_nxt) : '0;
    assign w_start_nxt    = w_wr_ptr_nxt - w_cnt_nxt[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_cap_cnt   <= '0;
            r_post_cnt  <= '0;
            r_start_ptr <= '0;
            r_trig_pos  <= '0;
            r_mode_lost <= 1'b0;
            r_mode_q    <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_zero   <= 1'b1;
        end else begin
            r_mode_q   <= cap_mode_vld;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_cap_cnt  <= w_cnt_nxt;
            r_post_cnt <= w_post_nxt;
            if (!arm) begin
                r_start_ptr <= '0;
                r_trig_pos  <= '0;
                r_mode_lost <= 1'b0;
            end else if (w_enter_done) begin
                r_start_ptr <= w_start_nxt;
                r_trig_pos  <= w_trig_pos_nxt;
                if (w_mode_fall) begin
                    r_mode_lost <= 1'b1;
                end
            end
            r_rd_vld <= w_rd_go;
            if (w_rd_go) begin
                r_rd_zero <= ({1'b0, rd_addr} >= r_cap_cnt);
            end
        end
    end

    assign w_rd_phys = r_start_ptr + rd_addr;

    cap_sink_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_ptr),
        .wdata (cap_data),
        .re    (w_rd_go),
        .raddr (w_rd_phys),
        .rdata (w_ram_q)
    );

    assign cap_cnt     = r_cap_cnt;
    assign trig_pos    = r_trig_pos;
    assign mode_lost   = r_mode_lost;
    assign rd_data_vld = r_rd_vld;
    assign rd_data     = r_rd_zero ? '0 : w_ram_q;

endmodule
`default_nettype wire

// File: tb/tb_cap_dbg_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_cap_dbg_sink
// Purpose  : Scoreboard bench for cap_dbg_sink with a queue-based buffer model.
// Revision : 1.0
// ============================================================================
module tb_cap_dbg_sink;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] cap_data;
    logic              cap_data_vld;
    logic              cap_mode_vld;
    logic              arm;
    logic              trig_in;
    logic [DATA_W-1:0] trig_mask;
    logic [DATA_W-1:0] trig_val;
    logic [ADDR_W:0]   post_len;
    logic [2:0]        cap_state;
    logic              cap_done;
    logic [ADDR_W:0]   cap_cnt;
    logic [ADDR_W:0]   trig_pos;
    logic              mode_lost;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_vld;

    int n_checks = 0;
    int n_err    = 0;
    logic [DATA_W-1:0] rd_q[$];
    logic [DATA_W-1:0] model[$];

    cap_dbg_sink #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cap_data(cap_data), .cap_data_vld(cap_data_vld),
        .cap_mode_vld(cap_mode_vld), .arm(arm), .trig_in(trig_in),
        .trig_mask(trig_mask), .trig_val(trig_val), .post_len(post_len),
        .cap_state(cap_state), .cap_done(cap_done), .cap_cnt(cap_cnt),
        .trig_pos(trig_pos), .mode_lost(mode_lost), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_vld(rd_data_vld)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Read monitor: every valid readout must match the oldest pending expectation.
    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        if (rst_n && rd_data_vld) begin
            n_checks++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got valid data 0x%0h expected no readout", rd_data);
            end else begin
                e = rd_q.pop_front();
                if (rd_data !== e) begin
                    n_err++;
                    $display("FAIL rd_data: got 0x%0h expected 0x%0h", rd_data, e);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [DATA_W-1:0] pdata();
        return $urandom & 32'h7FFF_FFFF;
    endfunction

    task automatic send(input logic [DATA_W-1:0] d, input bit noise);
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
            cap_data_vld = 1'b0;
            cap_data     = pdata();
            trig_in      = noise && ($urandom_range(0, 1) == 1);
            step();
        end
        trig_in      = 1'b0;
        cap_data     = d;
        cap_data_vld = 1'b1;
        step();
        cap_data_vld = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] seqd(input int base, input int i);
        return DATA_W'(base + i);
    endfunction

    // kind: 0 = trig_in with sample, 1 = trig_in without sample, 2 = data match.
    // drop > 0: cap_mode_vld falls after that many post samples. seq_base < 0: random data.
    task automatic capture(input int n_pre, input int plen, input int kind,
                           input int drop, input int seq_base);
        int eff, np, sent, target, total, cnt, tp, k;
        logic [DATA_W-1:0] d, tv;
        model.delete();
        eff      = (plen > DEPTH) ? DEPTH : plen;
        post_len = (ADDR_W+1)'(plen);
        if (kind == 2) begin
            if (seq_base >= 0) begin
                trig_mask = 32'hFFFF_FFFF;
                tv        = seqd(seq_base, n_pre);
            end else begin
                trig_mask = 32'h8000_00FF;
                tv        = 32'h8000_0000 | ($urandom & 32'hFF);
            end
        end else begin
            trig_mask = '0;
            tv        = $urandom;
        end
        trig_val = tv;

        cap_mode_vld = 1'b1;
        arm          = 1'b1;
        cap_data_vld = 1'b1;
        cap_data     = 32'hDEAD_0001;
        step();
        cap_data_vld = 1'b0;
        check("armed_state", cap_state, 1);
        check("armed_cnt", cap_cnt, 0);
        rd_en = 1'b1; rd_addr = '0;
        step();
        rd_en = 1'b0;
        check("rd_armed_vld", rd_data_vld, 0);

        k = 0;
        for (int i = 0; i < n_pre; i++) begin
            d = (seq_base >= 0) ? seqd(seq_base, k) : pdata();
            k++;
            send(d, 1'b0);
            model.push_back(d);
        end

        if (kind == 2) d = (seq_base >= 0) ? tv : (($urandom & 32'h7FFF_FF00) | tv);
        else           d = (seq_base >= 0) ? seqd(seq_base, k) : pdata();
        k++;
        cap_data     = d;
        cap_data_vld = (kind != 1);
        trig_in      = (kind != 2);
        np = 0;
        if (kind != 1 && eff > 0) begin
            model.push_back(d);
            np = 1;
        end
        step();
        trig_in      = 1'b0;
        cap_data_vld = 1'b0;
        if (eff == 0) check("done_next_cycle", cap_state, 3);

        sent   = (kind != 1) ? 1 : 0;
        target = (drop > 0) ? drop : eff;
        total  = (drop > 0) ? drop : eff + 3;
        while (sent < total) begin
            d = (seq_base >= 0) ? seqd(seq_base, k) : pdata();
            k++;
            send(d, 1'b1);
            sent++;
            if (np < target) begin
                model.push_back(d);
                np++;
            end
        end
        if (drop > 0) begin
            cap_mode_vld = 1'b0;
            step();
        end
        for (int i = 0; i < 4 && cap_done !== 1'b1; i++) step();
        check("cap_done", cap_done, 1);

        while (model.size() > DEPTH) void'(model.pop_front());
        cnt = model.size();
        tp  = (cnt > np) ? cnt - np : 0;
        check("cap_cnt", cap_cnt, cnt);
        check("trig_pos", trig_pos, tp);
        check("mode_lost", mode_lost, (drop > 0) ? 1 : 0);
        check("done_state", cap_state, 3);

        for (int i = 0; i < DEPTH + 4; i++) begin
            int a;
            a = (i < DEPTH) ? i : $urandom_range(0, DEPTH - 1);
            rd_en   = 1'b1;
            rd_addr = ADDR_W'(a);
            rd_q.push_back((a < cnt) ? model[a] : '0);
            step();
            if ($urandom_range(0, 3) == 0) begin
                rd_en = 1'b0;
                step();
            end
        end
        rd_en = 1'b0;
        step();
        step();
        check("rd_drain", rd_q.size(), 0);

        arm = 1'b0;
        step();
        check("idle_state", cap_state, 0);
        check("idle_cnt", cap_cnt, 0);
        check("idle_trig_pos", trig_pos, 0);
        check("idle_done", cap_done, 0);
        check("idle_mode_lost", mode_lost, 0);
        cap_mode_vld = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, cap_state, 0);
        check({tag, "_done"}, cap_done, 0);
        check({tag, "_cnt"}, cap_cnt, 0);
        check({tag, "_trig_pos"}, trig_pos, 0);
        check({tag, "_mode_lost"}, mode_lost, 0);
        check({tag, "_rd_vld"}, rd_data_vld, 0);
        check({tag, "_rd_data"}, rd_data, 0);
    endtask

    initial begin
        int plen, eff, kind, drop;
        rst_n = 1'b0;
        cap_data = '0; cap_data_vld = 1'b0; cap_mode_vld = 1'b1; arm = 1'b0;
        trig_in = 1'b0; trig_mask = '0; trig_val = '0; post_len = '0;
        rd_en = 1'b0; rd_addr = '0;
        repeat (2) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        capture(10, 4, 0, -1, 'h100);
        capture(40, 4, 2, -1, 0);
        capture(5, 0, 0, -1, -1);
        capture(6, 8, 0, 3, -1);
        capture(12, 16, 2, -1, -1);
        capture(3, 20, 1, -1, -1);
        capture(0, 1, 0, -1, -1);
        capture(20, 0, 1, -1, -1);

        // abort mid-POST, then a fresh capture must start from empty
        post_len = 5'd8; trig_mask = '0; arm = 1'b1;
        step();
        for (int i = 0; i < 5; i++) send(pdata(), 1'b0);
        cap_data = pdata(); cap_data_vld = 1'b1; trig_in = 1'b1;
        step();
        trig_in = 1'b0; cap_data_vld = 1'b0;
        check("abort_in_post", cap_state, 2);
        send(pdata(), 1'b1);
        send(pdata(), 1'b1);
        arm = 1'b0;
        step();
        check("abort_state", cap_state, 0);
        check("abort_cnt", cap_cnt, 0);
        check("abort_trig_pos", trig_pos, 0);
        check("abort_done", cap_done, 0);
        capture(4, 3, 0, -1, -1);

        for (int r = 0; r < 8; r++) begin
            plen = $urandom_range(0, 31);
            eff  = (plen > DEPTH) ? DEPTH : plen;
            kind = $urandom_range(0, 2);
            drop = (eff >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, eff - 1) : -1;
            capture($urandom_range(0, 40), plen, kind, drop, -1);
        end

        // asynchronous reset in the middle of a capture
        post_len = 5'd6; arm = 1'b1;
        step();
        for (int i = 0; i < 3; i++) send(pdata(), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        arm = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        capture(7, 3, 0, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
